// File: rtl/serial_add_sequencer_pkg.sv
// ============================================================================
// Module  : serial_add_sequencer_pkg
// Purpose : Shared state encodings for the bit-serial adder sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_add_sequencer_fulladder.sv
// ============================================================================
// Module  : fulladder
// Purpose : 1-bit full adder cell shared with the ripple-carry adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
  output logic Sum,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module  : serial_add_sequencer
// Purpose : Bit-serial adder, LSB-first through one full adder, valid/ready I/O.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  fulladder u_fa (
    .Sum  (fa_sum),
    .Cout (fa_cout),
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
  if (WIDTH == 1) begin : g_sum_single
    assign sum_next = fa_sum;
  end else begin : g_sum_multi
    assign sum_next = {fa_sum, sum_q[WIDTH-1:1]};
  end

  assign In_ready  = (state_q == ST_IDLE) && Rst_n;
  assign Out_valid = (state_q == ST_DONE);
  assign Sum       = sum_q;
  assign Cout      = carry_q;
  assign Ovf       = c_msb_q ^ carry_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (In_valid && In_ready) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          count_d = '0;
          sum_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_d   = sum_next;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        if (count_q == LAST) begin
          c_msb_d = carry_q;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (Out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
// Module  : tb_serial_add_sequencer
// Purpose : Self-checking bench for WIDTH=8 and WIDTH=1 serial adder builds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
  logic [0:0]   a1, b1, sum1;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp8_t;

  exp8_t      sb8[$];
  logic [2:0] sb1[$];
  int         acc_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         n_acc  = 0;
  int         n_acc1 = 0;

  serial_add_sequencer #(.WIDTH(W)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .In_valid(in_valid), .In_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Out_valid(out_valid), .Out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  serial_add_sequencer #(.WIDTH(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .In_valid(in_valid1), .In_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1), .Out_valid(out_valid1), .Out_ready(out_ready1),
    .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp8_t model8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    exp8_t      e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  function automatic logic [2:0] model1(input logic x, input logic y, input logic c);
    logic [1:0] t;
    t = {1'b0, x} + {1'b0, y} + {1'b0, c};
    return {t[0], t[1], (x == y) && (t[0] != x)};
  endfunction

  // Scoreboards: push on accept, pop on result handshake.
  always @(negedge clk) begin
    exp8_t      e;
    logic [2:0] e1;
    if (in_valid && in_ready) begin
      sb8.push_back(model8(a, b, cin));
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    if (out_valid === 1'b1 && out_ready) begin
      chk("sb8_nonempty", 64'(sb8.size() != 0), 64'd1);
      if (sb8.size() != 0) begin
        e = sb8.pop_front();
        chk("sum8", 64'(sum), 64'(e.s));
        chk("cout8", 64'(cout), 64'(e.c));
        chk("ovf8", 64'(ovf), 64'(e.o));
      end
    end
    if (in_valid1 && in_ready1) begin
      sb1.push_back(model1(a1[0], b1[0], cin1));
      n_acc1++;
    end
    if (out_valid1 === 1'b1 && out_ready1) begin
      chk("sb1_nonempty", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("res1", 64'({sum1[0], cout1, ovf1}), 64'(e1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n0;
    int k;
    n0 = n_acc; a = x; b = y; cin = c; in_valid = 1'b1; k = 0;
    while (!in_ready && k < 50) begin step(); k++; end
    step();
    in_valid = 1'b0;
    chk("accept8", 64'(n_acc - n0), 64'd1);
  endtask

  task automatic wait_out8(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin step(); k++; end
  endtask

  initial begin
    int k;
    int n0;
    int bad;
    logic [W-1:0] ops [3][2];
    ops[0][0] = 8'h12; ops[0][1] = 8'h34;
    ops[1][0] = 8'h80; ops[1][1] = 8'h80;
    ops[2][0] = 8'hC3; ops[2][1] = 8'h7E;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_in_ready1", 64'(in_ready1), 64'd1);

    // Reset in the middle of a SHIFT discards the operation.
    send8(8'hF0, 8'h0F, 1'b1);
    step(); step(); step();
    rst_n = 1'b0;
    step(); step();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    sb8.delete();
    bad = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid !== 1'b0) bad++; end
    chk("abort_never_presented", 64'(bad), 64'd0);

    // Directed sums with latency check.
    out_ready = 1'b1;
    send8(8'h3C, 8'h05, 1'b0);
    wait_out8(k);
    chk("latency8", 64'(k), 64'd8);
    step();
    chk("done_1cycle", 64'({out_valid, in_ready}), 64'b01);
    send8(8'hFF, 8'h01, 1'b0);
    wait_out8(k);
    step();
    send8(8'h7F, 8'h01, 1'b0);
    wait_out8(k);
    step();

    // Backpressure in DONE: outputs hold, new operands ignored.
    out_ready = 1'b0;
    send8(8'hAA, 8'h55, 1'b1);
    wait_out8(k);
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h11 + 8'(i); b = 8'h22; cin = 1'b0;
      step();
      chk("hold_sum", 64'(sum), 64'h00);
      chk("hold_cout_valid", 64'({cout, out_valid, in_ready}), 64'b110);
    end
    chk("hold_no_accept", 64'(n_acc - n0), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release", 64'({out_valid, in_ready}), 64'b01);

    // Back-to-back operations.
    n0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ops[i][0]; b = ops[i][1]; cin = 1'(i);
      k = 0;
      while (n_acc < n0 + i + 1 && k < 40) begin step(); k++; end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(n_acc - n0), 64'd3);
    k = 0;
    while ((sb8.size() != 0 || out_valid === 1'b1) && k < 40) begin step(); k++; end
    chk("b2b_drained", 64'(sb8.size()), 64'd0);
    if (acc_cyc.size() >= 3) begin
      chk("b2b_ii_0", 64'(acc_cyc[acc_cyc.size()-2] - acc_cyc[acc_cyc.size()-3]), 64'd10);
      chk("b2b_ii_1", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 64'd10);
    end

    // WIDTH=1 build: directed case then random run.
    out_ready1 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    k = 0;
    while (out_valid1 !== 1'b1 && k < 20) begin step(); k++; end
    chk("latency1", 64'(k), 64'd1);
    chk("w1_direct", 64'({sum1[0], cout1, ovf1}), 64'b110);
    step();

    n0 = n_acc1;
    in_valid1 = 1'b1;
    k = 0;
    while (n_acc1 < n0 + 1000 && k < 10000) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
      out_ready1 = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    chk("rand1_ops", 64'(n_acc1 - n0), 64'd1000);
    k = 0;
    while ((sb1.size() != 0 || out_valid1 === 1'b1) && k < 20) begin step(); k++; end
    chk("rand1_drained", 64'(sb1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
